// File: rtl/pmem_arbiter_if.sv
// Bundles the fetch, loader and program-memory signals around pmem_arbiter.
// slave is the arbiter's view; master is the view of the clients and the memory.
interface pmem_arbiter_if #(
  parameter int WORD_ADDR_W = 10
);
  logic                   if_req;
  logic [31:0]            if_addr;
  logic [31:0]            if_rdata;
  logic                   if_valid;
  logic                   if_stall;
  logic                   ld_req;
  logic                   ld_we;
  logic [31:0]            ld_addr;
  logic [31:0]            ld_wdata;
  logic                   ld_ack;
  logic                   ld_err;
  logic [31:0]            ld_rdata;
  logic                   mem_en;
  logic                   mem_we;
  logic [WORD_ADDR_W-1:0] mem_addr;
  logic [31:0]            mem_wdata;
  logic [31:0]            mem_rdata;

  modport slave (
    input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output if_rdata, if_valid, if_stall, ld_ack, ld_err, ld_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  if_rdata, if_valid, if_stall, ld_ack, ld_err, ld_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Arbitrates the single-port program memory between instruction fetch and the loader port.
// Define PMEM_ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module pmem_arbiter #(
  parameter int WORD_ADDR_W  = 10,
  parameter int MAX_LD_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  pmem_arbiter_if.slave bus
`ifdef PMEM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam logic [3:0] MAX_B = 4'(MAX_LD_BURST);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    LD_ACC  = 2'd1,
    LD_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             burst_cnt_q, burst_cnt_d;
  logic                   err_q, err_d;
  logic                   rd_q, rd_d;
  logic                   fetch_pend_q, fetch_pend_d;
  logic [31:0]            if_rdata_q, if_rdata_d;
  logic [31:0]            ld_rdata_q, ld_rdata_d;

  logic                   ld_in_range;
  logic                   if_stall;
  logic                   ld_ack;
  logic                   ld_err;
  logic                   mem_en;
  logic                   mem_we;
  logic [WORD_ADDR_W-1:0] mem_addr;
  logic [31:0]            mem_wdata;
  logic                   unused_addr_bits;

  assign ld_in_range      = (bus.ld_addr[31:WORD_ADDR_W+2] == '0);
  assign unused_addr_bits = ^{bus.if_addr[31:WORD_ADDR_W+2], bus.if_addr[1:0], bus.ld_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    err_d        = err_q;
    rd_d         = rd_q;
    fetch_pend_d = 1'b0;
    if_stall     = 1'b0;
    ld_ack       = 1'b0;
    ld_err       = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_q)
      FETCH: begin
        mem_en       = bus.if_req;
        mem_addr     = bus.if_addr[WORD_ADDR_W+1:2];
        fetch_pend_d = bus.if_req;
        // The grant cycle belongs to the burst; any FETCH cycle without a grant
        // (idle, or the forced fairness slot) ends the burst.
        if (bus.ld_req && (burst_cnt_q < MAX_B)) begin
          state_d = LD_ACC;
        end else begin
          burst_cnt_d = '0;
        end
      end
      LD_ACC: begin
        if_stall    = 1'b1;
        err_d       = !ld_in_range;
        rd_d        = !bus.ld_we;
        burst_cnt_d = burst_cnt_q + 4'd1;
        state_d     = LD_DONE;
        if (ld_in_range) begin
          mem_en    = 1'b1;
          mem_we    = bus.ld_we;
          mem_addr  = bus.ld_addr[WORD_ADDR_W+1:2];
          mem_wdata = bus.ld_wdata;
        end
      end
      LD_DONE: begin
        if_stall = 1'b1;
        ld_ack   = 1'b1;
        ld_err   = err_q;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Read data is passed straight through in its arrival cycle and held afterwards.
  assign if_rdata_d = fetch_pend_q ? bus.mem_rdata : if_rdata_q;
  assign ld_rdata_d = ((state_q == LD_DONE) && rd_q && !err_q) ? bus.mem_rdata : ld_rdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      burst_cnt_q  <= '0;
      err_q        <= 1'b0;
      rd_q         <= 1'b0;
      fetch_pend_q <= 1'b0;
      if_rdata_q   <= '0;
      ld_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      err_q        <= err_d;
      rd_q         <= rd_d;
      fetch_pend_q <= fetch_pend_d;
      if_rdata_q   <= if_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
    end
  end

  // Memory enable/address follow if_req combinationally, so gate them while reset is low.
  assign bus.mem_en    = mem_en & reset;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr & {WORD_ADDR_W{reset}};
  assign bus.mem_wdata = mem_wdata;
  assign bus.if_rdata  = if_rdata_d;
  assign bus.if_valid  = fetch_pend_q;
  assign bus.if_stall  = if_stall;
  assign bus.ld_ack    = ld_ack;
  assign bus.ld_err    = ld_err;
  assign bus.ld_rdata  = ld_rdata_d;

`ifdef PMEM_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = (if_stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a behavioural sync-read memory plus queue-based
// scoreboards for fetched words and loader acknowledgements.
module tb_pmem_arbiter;
  localparam int WAW  = 10;
  localparam int MAXB = 4;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } ld_exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pmem_arbiter_if #(.WORD_ADDR_W(WAW)) bus ();

`ifdef PMEM_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
  pmem_arbiter #(.WORD_ADDR_W(WAW), .MAX_LD_BURST(MAXB)) dut (
    .clock(clock), .reset(reset), .bus(bus), .stall_cnt(stall_cnt)
  );
`else
  pmem_arbiter #(.WORD_ADDR_W(WAW), .MAX_LD_BURST(MAXB)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
`endif

  logic [31:0] pmem [0:(1<<WAW)-1];
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) pmem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= pmem[bus.mem_addr];
    end
  end

  int          total = 0;
  int          bad   = 0;
  logic [31:0] shadow [int];
  logic [31:0] exp_if [$];
  ld_exp_t     exp_ld [$];
  logic [31:0] last_ld_rdata = '0;
  logic        exp_stall [$];
  logic        exp_ack [$];

  logic        s_if_stall, s_if_valid, s_ld_ack, s_mem_en, s_mem_we;
  logic [9:0]  s_mem_addr;
  logic [31:0] s_if_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Samples the cycle at negedge, scoreboards returned data, then steps to posedge+1.
  task automatic cyc();
    ld_exp_t e;
    @(negedge clock);
    s_if_stall = bus.if_stall;
    s_if_valid = bus.if_valid;
    s_ld_ack   = bus.ld_ack;
    s_mem_en   = bus.mem_en;
    s_mem_we   = bus.mem_we;
    s_mem_addr = bus.mem_addr;
    s_if_rdata = bus.if_rdata;
    if (bus.if_valid === 1'b1) begin
      if (exp_if.size() == 0) chk("if_valid_unexpected", 32'(bus.if_valid), 32'd0);
      else chk("if_rdata", bus.if_rdata, exp_if.pop_front());
    end
    if (bus.ld_ack === 1'b1) begin
      if (exp_ld.size() == 0) chk("ld_ack_unexpected", 32'(bus.ld_ack), 32'd0);
      else begin
        e = exp_ld.pop_front();
        chk("ld_err", 32'(bus.ld_err), 32'(e.err));
        chk("ld_rdata", bus.ld_rdata, e.rdata);
      end
    end
    @(posedge clock);
    #1;
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'(addr[WAW+1:2]);
  endfunction

  task automatic ld_expect(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    ld_exp_t e;
    e.err = (addr[31:WAW+2] != '0);
    if (!e.err) begin
      if (we) shadow[word_of(addr)] = wd;
      else last_ld_rdata = shadow[word_of(addr)];
    end
    e.rdata = last_ld_rdata;
    exp_ld.push_back(e);
  endtask

  task automatic ld_access(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic early_drop);
    logic in_range;
    in_range     = (addr[31:WAW+2] == '0);
    bus.ld_req   = 1'b1;
    bus.ld_we    = we;
    bus.ld_addr  = addr;
    bus.ld_wdata = wd;
    ld_expect(we, addr, wd);
    cyc();
    chk({tag, "_c0_stall"}, 32'(s_if_stall), 32'd0);
    chk({tag, "_c0_ack"}, 32'(s_ld_ack), 32'd0);
    if (early_drop) bus.ld_req = 1'b0;
    cyc();
    chk({tag, "_c1_stall"}, 32'(s_if_stall), 32'd1);
    chk({tag, "_c1_mem_en"}, 32'(s_mem_en), 32'(in_range));
    chk({tag, "_c1_mem_we"}, 32'(s_mem_we), 32'(in_range & we));
    if (in_range) chk({tag, "_c1_mem_addr"}, 32'(s_mem_addr), 32'(addr[WAW+1:2]));
    bus.ld_req = 1'b0;
    cyc();
    chk({tag, "_c2_ack"}, 32'(s_ld_ack), 32'd1);
    chk({tag, "_c2_stall"}, 32'(s_if_stall), 32'd1);
  endtask

  task automatic fetch_run(input string tag, input logic [31:0] addr, input int n);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    for (int i = 0; i < n; i++) begin
      exp_if.push_back(shadow[word_of(addr)]);
      cyc();
      chk({tag, "_mem_en"}, 32'(s_mem_en), 32'd1);
      chk({tag, "_mem_addr"}, 32'(s_mem_addr), 32'(addr[WAW+1:2]));
      chk({tag, "_stall"}, 32'(s_if_stall), 32'd0);
      chk({tag, "_valid"}, 32'(s_if_valid), (i > 0) ? 32'd1 : 32'd0);
    end
    bus.if_req = 1'b0;
    cyc();
    chk({tag, "_drain_valid"}, 32'(s_if_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h10;
    bus.ld_req   = 1'b1;
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 32'h20;
    bus.ld_wdata = 32'h5555_AAAA;

    // Reset held: everything quiet even with both requesters asserted.
    cyc();
    cyc();
    chk("rst_mem_en", 32'(s_mem_en), 32'd0);
    chk("rst_mem_we", 32'(s_mem_we), 32'd0);
    chk("rst_if_stall", 32'(s_if_stall), 32'd0);
    chk("rst_if_valid", 32'(s_if_valid), 32'd0);
    chk("rst_ld_ack", 32'(s_ld_ack), 32'd0);
    chk("rst_ld_err", 32'(bus.ld_err), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_ld_rdata", bus.ld_rdata, 32'd0);
    bus.if_req = 1'b0;
    bus.ld_req = 1'b0;
    reset      = 1'b1;
    cyc();

    // Preload words used later.
    ld_access("wr10", 1'b1, 32'h10, 32'h1111_2222, 1'b0);
    ld_access("wr00", 1'b1, 32'h00, 32'h0BAD_F00D, 1'b0);
    ld_access("wr24", 1'b1, 32'h24, 32'h2424_2424, 1'b0);

    // Write then fetch of the same word.
    ld_access("wr20", 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0);
    fetch_run("f20", 32'h20, 1);
    cyc();
    chk("f20_hold", s_if_rdata, 32'hDEAD_BEEF);

    fetch_run("f10", 32'h10, 5);

    // Request dropped early still completes.
    ld_access("rd10", 1'b0, 32'h10, 32'h0, 1'b1);

    // Out of range: acked with error, memory untouched (0x1000 aliases word 0).
    ld_access("oor_wr", 1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0);
    ld_access("rd00", 1'b0, 32'h00, 32'h0, 1'b0);
    ld_access("oor_rd", 1'b0, 32'h8000_0000, 32'h0, 1'b0);
    cyc();

    // Fetch and loader request together.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h24;
    bus.ld_req  = 1'b1;
    bus.ld_we   = 1'b0;
    bus.ld_addr = 32'h20;
    ld_expect(1'b0, 32'h20, 32'h0);
    exp_if.push_back(shadow[word_of(32'h24)]);
    cyc();
    chk("sim_c0_stall", 32'(s_if_stall), 32'd0);
    chk("sim_c0_mem_en", 32'(s_mem_en), 32'd1);
    chk("sim_c0_mem_addr", 32'(s_mem_addr), 32'd9);
    cyc();
    chk("sim_c1_stall", 32'(s_if_stall), 32'd1);
    chk("sim_c1_valid", 32'(s_if_valid), 32'd1);
    chk("sim_c1_mem_addr", 32'(s_mem_addr), 32'd8);
    bus.ld_req = 1'b0;
    cyc();
    chk("sim_c2_stall", 32'(s_if_stall), 32'd1);
    chk("sim_c2_valid", 32'(s_if_valid), 32'd0);
    chk("sim_c2_ack", 32'(s_ld_ack), 32'd1);
    chk("sim_c2_hold", s_if_rdata, 32'h2424_2424);
    exp_if.push_back(shadow[word_of(32'h24)]);
    cyc();
    chk("sim_c3_stall", 32'(s_if_stall), 32'd0);
    bus.if_req = 1'b0;
    cyc();

    // Six held loader reads with fetch busy: one extra free slot after MAXB accesses.
    for (int k = 0; k < 6; k++) begin
      if (k == MAXB) begin
        exp_stall.push_back(1'b0);
        exp_ack.push_back(1'b0);
      end
      exp_stall.push_back(1'b0); exp_ack.push_back(1'b0);
      exp_stall.push_back(1'b1); exp_ack.push_back(1'b0);
      exp_stall.push_back(1'b1); exp_ack.push_back(1'b1);
      ld_expect(1'b0, 32'h20, 32'h0);
    end
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    bus.ld_req  = 1'b1;
    bus.ld_we   = 1'b0;
    bus.ld_addr = 32'h20;
    for (int c = 0; c < exp_stall.size(); c++) begin
      if (!exp_stall[c]) exp_if.push_back(shadow[word_of(32'h10)]);
      cyc();
      chk($sformatf("burst_stall_%0d", c), 32'(s_if_stall), 32'(exp_stall[c]));
      chk($sformatf("burst_ack_%0d", c), 32'(s_ld_ack), 32'(exp_ack[c]));
    end
    bus.ld_req = 1'b0;
    bus.if_req = 1'b0;
    cyc();
    cyc();

    // Reset in the middle of a write access.
    bus.ld_req   = 1'b1;
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 32'h24;
    bus.ld_wdata = 32'h9999_9999;
    cyc();
    #2;
    chk("abort_pre_we", 32'(bus.mem_we), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort_mem_en", 32'(bus.mem_en), 32'd0);
    chk("abort_stall", 32'(bus.if_stall), 32'd0);
    chk("abort_ack", 32'(bus.ld_ack), 32'd0);
    chk("abort_if_rdata", bus.if_rdata, 32'd0);
    chk("abort_ld_rdata", bus.ld_rdata, 32'd0);
    bus.ld_req = 1'b0;
    cyc();
    chk("abort_c1_ack", 32'(s_ld_ack), 32'd0);
    cyc();
    chk("abort_c2_ack", 32'(s_ld_ack), 32'd0);
    reset         = 1'b1;
    last_ld_rdata = '0;
    cyc();
    ld_access("rd24", 1'b0, 32'h24, 32'h0, 1'b0);
    cyc();

    chk("if_queue_empty", 32'(exp_if.size()), 32'd0);
    chk("ld_queue_empty", 32'(exp_ld.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
